// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MMIO decode for UART RX/TX buffers and cycle/instret counters
module mmio_uart_ctrl #(
    parameter logic [31:0] ADDR_CTRL = 32'h8000_0000,
    parameter logic [31:0] ADDR_RX   = 32'h8000_0004,
    parameter logic [31:0] ADDR_TX   = 32'h8000_0008,
    parameter logic [31:0] ADDR_CC   = 32'h8000_0010,
    parameter logic [31:0] ADDR_IC   = 32'h8000_0014,
    parameter logic [31:0] ADDR_RST  = 32'h8000_0018
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_rd,
    input  logic        mmio_wr,
    input  logic [7:0]  mmio_wdata,
    input  logic        inst_retire,
    output logic [31:0] mmio_rdata,
    output logic        mmio_hit,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    logic        is_ld;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic        rx_full;
    logic [7:0]  rx_byte;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic        rx_take;
    logic        rx_drain;
    logic        tx_take;
    logic        tx_done;
    logic        cnt_clr;

    // A combined rd+wr access behaves as a store only.
    assign is_ld    = mmio_rd & ~mmio_wr;
    assign rx_take  = uart_rx_valid & ~rx_full;
    assign rx_drain = is_ld & (mmio_addr == ADDR_RX) & rx_full;
    assign tx_take  = mmio_wr & (mmio_addr == ADDR_TX) & (~uart_tx_valid | uart_tx_ready);
    assign tx_done  = uart_tx_valid & uart_tx_ready;
    assign cnt_clr  = mmio_wr & (mmio_addr == ADDR_RST);

    assign uart_rx_ready = ~rx_full;

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 32'h0;
        if (is_ld) begin
            case (mmio_addr)
                ADDR_CTRL: begin
                    rd_hit  = 1'b1;
                    rd_data = {30'h0, rx_full, ~uart_tx_valid};
                end
                ADDR_RX: begin
                    rd_hit  = 1'b1;
                    rd_data = {24'h0, rx_byte};
                end
                ADDR_CC: begin
                    rd_hit  = 1'b1;
                    rd_data = cycle_cnt;
                end
                ADDR_IC: begin
                    rd_hit  = 1'b1;
                    rd_data = inst_cnt;
                end
                default: begin
                    rd_hit  = 1'b0;
                    rd_data = 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_rdata <= 32'h0;
            mmio_hit   <= 1'b0;
        end else begin
            mmio_rdata <= rd_data;
            mmio_hit   <= rd_hit;
        end
    end

    // Capture and drain never coincide: capture needs the buffer empty, drain needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full <= 1'b0;
            rx_byte <= 8'h0;
        end else if (rx_take) begin
            rx_full <= 1'b1;
            rx_byte <= uart_rx_data;
        end else if (rx_drain) begin
            rx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h0;
        end else if (tx_take) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= mmio_wdata;
        end else if (tx_done) begin
            uart_tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'h0;
            inst_cnt  <= 32'h0;
        end else if (cnt_clr) begin
            cycle_cnt <= 32'h0;
            inst_cnt  <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'h0, inst_retire};
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb/tb_mmio_uart_ctrl.sv - directed and randomized checks of mmio_uart_ctrl against a queue-based model
module tb_mmio_uart_ctrl;

    localparam logic [31:0] A_CTRL = 32'h8000_0000;
    localparam logic [31:0] A_RX   = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_CC   = 32'h8000_0010;
    localparam logic [31:0] A_IC   = 32'h8000_0014;
    localparam logic [31:0] A_RST  = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mmio_addr = 32'h0;
    logic        mmio_rd = 1'b0;
    logic        mmio_wr = 1'b0;
    logic [7:0]  mmio_wdata = 8'h0;
    logic        inst_retire = 1'b0;
    logic [31:0] mmio_rdata;
    logic        mmio_hit;
    logic [7:0]  uart_rx_data = 8'h0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: one-deep queues stand in for the RX buffer and TX holding register.
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_last = 8'h0;
    logic [7:0]  tx_last = 8'h0;
    logic [31:0] m_cc = 32'h0;
    logic [31:0] m_ic = 32'h0;
    logic [31:0] e_rdata = 32'h0;
    logic        e_hit = 1'b0;
    int          preload_seq = 0;
    int          preload_seen = 0;
    logic [31:0] preload_val = 32'h0;

    mmio_uart_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mmio_addr    (mmio_addr),
        .mmio_rd      (mmio_rd),
        .mmio_wr      (mmio_wr),
        .mmio_wdata   (mmio_wdata),
        .inst_retire  (inst_retire),
        .mmio_rdata   (mmio_rdata),
        .mmio_hit     (mmio_hit),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready),
        .uart_tx_data (uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic        ld;
        logic        hv;
        logic [31:0] rv;
        logic        drain;
        logic        store_ok;
        if (!rst_n) begin
            rx_q.delete();
            tx_q.delete();
            rx_last = 8'h0;
            tx_last = 8'h0;
            m_cc    = 32'h0;
            m_ic    = 32'h0;
            e_hit   = 1'b0;
            e_rdata = 32'h0;
            return;
        end
        if (preload_seq != preload_seen) begin
            m_cc = preload_val;
            preload_seen = preload_seq;
        end
        ld = mmio_rd && !mmio_wr;
        hv = 1'b0;
        rv = 32'h0;
        if (ld) begin
            if (mmio_addr == A_CTRL) begin
                hv = 1'b1;
                rv = (rx_q.size() != 0 ? 32'd2 : 32'd0) + (tx_q.size() == 0 ? 32'd1 : 32'd0);
            end else if (mmio_addr == A_RX) begin
                hv = 1'b1;
                rv = {24'h0, rx_last};
            end else if (mmio_addr == A_CC) begin
                hv = 1'b1;
                rv = m_cc;
            end else if (mmio_addr == A_IC) begin
                hv = 1'b1;
                rv = m_ic;
            end
        end
        drain    = (tx_q.size() != 0) && uart_tx_ready;
        store_ok = mmio_wr && (mmio_addr == A_TX) && (tx_q.size() == 0 || uart_tx_ready);
        if (drain) void'(tx_q.pop_front());
        if (store_ok) begin
            tx_q.push_back(mmio_wdata);
            tx_last = mmio_wdata;
        end
        if (uart_rx_valid && rx_q.size() == 0) begin
            rx_q.push_back(uart_rx_data);
            rx_last = uart_rx_data;
        end else if (ld && mmio_addr == A_RX && rx_q.size() != 0) begin
            void'(rx_q.pop_front());
        end
        if (mmio_wr && mmio_addr == A_RST) begin
            m_cc = 32'h0;
            m_ic = 32'h0;
        end else begin
            m_cc = m_cc + 32'd1;
            m_ic = m_ic + (inst_retire ? 32'd1 : 32'd0);
        end
        e_hit   = hv;
        e_rdata = rv;
    endtask

    always @(posedge clk) model_edge();

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            check_eq("m_rdata", mmio_rdata, e_rdata);
            check_eq("m_hit", 32'(mmio_hit), 32'(e_hit));
            check_eq("m_rx_ready", 32'(uart_rx_ready), 32'(rx_q.size() == 0));
            check_eq("m_tx_valid", 32'(uart_tx_valid), 32'(tx_q.size() != 0));
            check_eq("m_tx_data", 32'(uart_tx_data), 32'(tx_last));
        end
    endtask

    task automatic idle();
        mmio_rd    = 1'b0;
        mmio_wr    = 1'b0;
        mmio_addr  = 32'h0;
        mmio_wdata = 8'h0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output logic h);
        mmio_rd   = 1'b1;
        mmio_wr   = 1'b0;
        mmio_addr = a;
        step();
        d = mmio_rdata;
        h = mmio_hit;
        idle();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [7:0] w);
        mmio_rd    = 1'b0;
        mmio_wr    = 1'b1;
        mmio_addr  = a;
        mmio_wdata = w;
        step();
        idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdata"}, mmio_rdata, 32'h0);
        check_eq({tag, "_hit"}, 32'(mmio_hit), 32'h0);
        check_eq({tag, "_rx_ready"}, 32'(uart_rx_ready), 32'h1);
        check_eq({tag, "_tx_valid"}, 32'(uart_tx_valid), 32'h0);
        check_eq({tag, "_tx_data"}, 32'(uart_tx_data), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        h;
        logic        pulses[100];
        logic [31:0] bad_addrs[4];
        logic [31:0] rnd_addrs[9];

        bad_addrs = '{32'h8000_000C, 32'h8000_0008, 32'h8000_0001, 32'h0000_1000};
        rnd_addrs = '{A_CTRL, A_RX, A_TX, A_CC, A_IC, A_RST, 32'h8000_000C, 32'h8000_0002, 32'h0000_1000};

        // Reset state, then counters from release: 100 cycles with 37 retire pulses.
        step();
        step();
        check_reset_outputs("rst0");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) pulses[i] = (i < 37);
        for (int i = 99; i > 0; i--) begin
            int j;
            logic t;
            j = int'($urandom_range(0, i));
            t = pulses[i];
            pulses[i] = pulses[j];
            pulses[j] = t;
        end
        for (int i = 0; i < 100; i++) begin
            inst_retire = pulses[i];
            step();
        end
        inst_retire = 1'b0;
        do_load(A_CC, d, h);
        check_eq("cc_100", d, 32'd100);
        check_eq("cc_100_hit", 32'(h), 32'h1);
        do_load(A_IC, d, h);
        check_eq("ic_37", d, 32'd37);
        do_load(A_CTRL, d, h);
        check_eq("ctrl_idle", d, 32'h1);

        do_store(A_RST, 8'hFF);
        do_load(A_CC, d, h);
        check_eq("cc_clr", d, 32'h0);
        do_load(A_IC, d, h);
        check_eq("ic_clr", d, 32'h0);

        // Wrap: preload the cycle counter to all-ones just before an edge.
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        preload_val = 32'hFFFF_FFFF;
        preload_seq++;
        #1 release dut.cycle_cnt;
        do_load(A_CC, d, h);
        check_eq("cc_max", d, 32'hFFFF_FFFF);
        do_load(A_CC, d, h);
        check_eq("cc_wrap", d, 32'h0);

        // RX path.
        uart_rx_data  = 8'h5A;
        uart_rx_valid = 1'b1;
        step();
        uart_rx_valid = 1'b0;
        check_eq("rx_ready_low", 32'(uart_rx_ready), 32'h0);
        do_load(A_CTRL, d, h);
        check_eq("ctrl_rx_full", d, 32'h3);
        do_load(A_RX, d, h);
        check_eq("rx_byte", d, 32'h5A);
        check_eq("rx_hit", 32'(h), 32'h1);
        do_load(A_RX, d, h);
        check_eq("rx_again", d, 32'h5A);
        do_load(A_CTRL, d, h);
        check_eq("ctrl_rx_empty", d, 32'h1);

        // TX path.
        uart_tx_ready = 1'b0;
        do_store(A_TX, 8'h41);
        do_store(A_TX, 8'h42);
        check_eq("tx_hold_data", 32'(uart_tx_data), 32'h41);
        check_eq("tx_hold_valid", 32'(uart_tx_valid), 32'h1);
        do_load(A_CTRL, d, h);
        check_eq("ctrl_tx_busy", d, 32'h0);
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;
        check_eq("tx_drained", 32'(uart_tx_valid), 32'h0);
        do_store(A_TX, 8'h44);
        uart_tx_ready = 1'b1;
        do_store(A_TX, 8'h43);
        uart_tx_ready = 1'b0;
        check_eq("tx_same_cycle_valid", 32'(uart_tx_valid), 32'h1);
        check_eq("tx_same_cycle_data", 32'(uart_tx_data), 32'h43);
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;

        // Decode misses and ignored store to a read-only address.
        for (int i = 0; i < 4; i++) begin
            do_load(bad_addrs[i], d, h);
            check_eq($sformatf("miss_rdata_%0d", i), d, 32'h0);
            check_eq($sformatf("miss_hit_%0d", i), 32'(h), 32'h0);
        end
        do_store(A_CC, 8'hAA);
        step();

        // Simultaneous rd+wr is a store only.
        mmio_rd    = 1'b1;
        mmio_wr    = 1'b1;
        mmio_addr  = A_TX;
        mmio_wdata = 8'h7E;
        step();
        idle();
        check_eq("rdwr_hit", 32'(mmio_hit), 32'h0);
        check_eq("rdwr_data", 32'(uart_tx_data), 32'h7E);
        check_eq("rdwr_valid", 32'(uart_tx_valid), 32'h1);
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;

        // Back-to-back CC then RX loads.
        uart_rx_data  = 8'h33;
        uart_rx_valid = 1'b1;
        step();
        uart_rx_valid = 1'b0;
        do_load(A_CC, d, h);
        check_eq("b2b_cc_hit", 32'(h), 32'h1);
        do_load(A_RX, d, h);
        check_eq("b2b_rx", d, 32'h33);
        check_eq("b2b_rx_hit", 32'(h), 32'h1);

        // Reset mid-operation with both buffers occupied.
        do_store(A_TX, 8'h55);
        uart_rx_data  = 8'h66;
        uart_rx_valid = 1'b1;
        step();
        uart_rx_valid = 1'b0;
        check_eq("pre_rst_rx_full", 32'(uart_rx_ready), 32'h0);
        check_eq("pre_rst_tx_valid", 32'(uart_tx_valid), 32'h1);
        #1 rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("rst1");
        #1 rst_n = 1'b1;
        do_load(A_CTRL, d, h);
        check_eq("rst1_ctrl", d, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int op;
            op            = int'($urandom_range(0, 3));
            mmio_addr     = rnd_addrs[$urandom_range(0, 8)];
            mmio_rd       = (op == 1) || (op == 3);
            mmio_wr       = (op == 2) || (op == 3);
            mmio_wdata    = 8'($urandom);
            inst_retire   = 1'($urandom);
            uart_rx_valid = 1'($urandom);
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = ($urandom_range(0, 3) == 0);
            step();
        end
        idle();
        inst_retire   = 1'b0;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
